// File: rtl/draw_pkg.sv
// Shared types and constants for the sprite/clear draw sequencer and its helpers.
package draw_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } draw_state_e;

  localparam int unsigned DEF_SPRITE_W = 40;
  localparam int unsigned DEF_SPRITE_H = 40;
  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;

  // Wide coordinates come in one bit wider than the screen so overflow is visible here.
  function automatic logic on_screen(input logic [8:0] wx, input logic [7:0] wy,
                                     input int unsigned sw, input int unsigned sh);
    return (32'(wx) < sw) && (32'(wy) < sh);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Row-major col/row counter with runtime wrap limits; o_last flags the final cell.
module scan_counter #(
  parameter int unsigned COL_W = 8,
  parameter int unsigned ROW_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [COL_W-1:0] i_w,
  input  logic [ROW_W-1:0] i_h,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_last
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_col_end;
  logic             w_row_end;

  assign w_col_end = (r_col == i_w - COL_W'(1));
  assign w_row_end = (r_row == i_h - ROW_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_col_end && w_row_end;

endmodule

// File: rtl/sprite_draw_seq.sv
// Draws one sprite from a synchronous ROM, or clears the screen, behind a start/done handshake.
module sprite_draw_seq
  import draw_pkg::*;
#(
  parameter int unsigned SPRITE_W = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H = DEF_SPRITE_H,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_clear_mode,
  input  logic [7:0]        i_x_origin,
  input  logic [6:0]        i_y_origin,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [2:0]        i_rom_color,
  output logic [7:0]        o_x,
  output logic [6:0]        o_y,
  output logic [2:0]        o_color,
  output logic              o_plot,
  output logic              o_busy,
  output logic              o_done
);

  draw_state_e       r_state;
  draw_state_e       w_state_next;
  logic              r_clear_mode;
  logic [7:0]        r_x_org;
  logic [6:0]        r_y_org;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] w_rom_addr_next;

  logic [7:0]        w_col;
  logic [6:0]        w_row;
  logic              w_last;
  logic [7:0]        w_lim_w;
  logic [6:0]        w_lim_h;
  logic              w_accept;
  logic              w_scan;
  logic [8:0]        w_wide_x;
  logic [7:0]        w_wide_y;

  // Stage 1 aligns pixel geometry with the ROM's one-cycle read latency.
  logic              r_s1_occ;
  logic              r_s1_clear;
  logic [8:0]        r_s1_x;
  logic [7:0]        r_s1_y;
  logic              w_s1_on;

  logic [7:0]        r_x;
  logic [6:0]        r_y;
  logic [2:0]        r_color;
  logic              r_plot;

  assign w_accept = (r_state == StIdle) && i_start;
  assign w_scan   = (r_state == StScan);
  assign w_lim_w  = r_clear_mode ? 8'(SCREEN_W) : 8'(SPRITE_W);
  assign w_lim_h  = r_clear_mode ? 7'(SCREEN_H) : 7'(SPRITE_H);

  scan_counter #(
    .COL_W (8),
    .ROW_W (7)
  ) u_scan_counter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_accept),
    .i_advance (w_scan),
    .i_w       (w_lim_w),
    .i_h       (w_lim_h),
    .o_col     (w_col),
    .o_row     (w_row),
    .o_last    (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StScan;
      StScan:  if (w_last) w_state_next = StFlush;
      // Hold until the last pixel has left stage 1 and reached the output register.
      StFlush: if (!r_s1_occ) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_rom_addr_next = '0;
    if (w_scan && !r_clear_mode && !w_last) begin
      w_rom_addr_next = r_rom_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_clear_mode <= 1'b0;
      r_x_org      <= '0;
      r_y_org      <= '0;
      r_rom_addr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rom_addr <= w_rom_addr_next;
      if (w_accept) begin
        r_clear_mode <= i_clear_mode;
        r_x_org      <= i_x_origin;
        r_y_org      <= i_y_origin;
      end
    end
  end

  assign w_wide_x = r_clear_mode ? {1'b0, w_col} : {1'b0, r_x_org} + {1'b0, w_col};
  assign w_wide_y = r_clear_mode ? {1'b0, w_row} : {1'b0, r_y_org} + {1'b0, w_row};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_occ   <= 1'b0;
      r_s1_clear <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      r_s1_occ <= w_scan;
      if (w_scan) begin
        r_s1_clear <= r_clear_mode;
        r_s1_x     <= w_wide_x;
        r_s1_y     <= w_wide_y;
      end
    end
  end

  assign w_s1_on = r_s1_occ && on_screen(r_s1_x, r_s1_y, SCREEN_W, SCREEN_H);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_color <= BLACK;
      r_plot  <= 1'b0;
    end else begin
      r_plot <= w_s1_on;
      if (w_s1_on) begin
        r_x     <= r_s1_x[7:0];
        r_y     <= r_s1_y[6:0];
        r_color <= r_s1_clear ? BLACK : i_rom_color;
      end
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_color    = r_color;
  assign o_plot     = r_plot;
  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StDone);

endmodule

// File: tb/tb_sprite_draw_seq.sv
// Randomized bench for sprite_draw_seq against a plain nested-loop reference of the draw.
module tb_sprite_draw_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clear_mode;
  logic [7:0]  x_origin;
  logic [6:0]  y_origin;
  logic [10:0] rom_addr;
  logic [2:0]  rom_color;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        plot;
  logic        busy;
  logic        done;

  logic [2:0]  salt;
  int          total = 0;
  int          bad = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  always #5 clk = ~clk;

  sprite_draw_seq u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_clear_mode (clear_mode),
    .i_x_origin   (x_origin),
    .i_y_origin   (y_origin),
    .o_rom_addr   (rom_addr),
    .i_rom_color  (rom_color),
    .o_x          (x),
    .o_y          (y),
    .o_color      (color),
    .o_plot       (plot),
    .o_busy       (busy),
    .o_done       (done)
  );

  function automatic logic [2:0] rom_fn(input logic [10:0] a);
    return a[2:0] ^ salt;
  endfunction

  // Synchronous ROM: data for the address seen at an edge is visible after that edge.
  always @(posedge clk) rom_color <= rom_fn(rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic build_model(input bit cm, input int xo, input int yo);
    int w, h, wx, wy;
    exp_q.delete();
    w = cm ? 160 : 40;
    h = cm ? 120 : 40;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        wx = cm ? c : xo + c;
        wy = cm ? r : yo + r;
        if (wx < 160 && wy < 120)
          exp_q.push_back({wx[7:0], wy[6:0], cm ? 3'b000 : rom_fn(11'(r * 40 + c))});
      end
    end
  endtask

  task automatic launch(input bit cm, input int xo, input int yo, input bit hold);
    @(negedge clk);
    clear_mode = cm;
    x_origin   = 8'(xo);
    y_origin   = 7'(yo);
    start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Called just after the edge that accepted start; runs the command to completion.
  task automatic observe(input string tag, input bit cm, input int xo, input int yo,
                         input bit disturb);
    int n, edges, done_at, addr_errs, busy_errs, exp_addr, lim;
    build_model(cm, xo, yo);
    obs_q.delete();
    n = cm ? 19200 : 1600;
    lim = n + 20;
    edges = 1;
    done_at = -1;
    addr_errs = 0;
    busy_errs = 0;
    while (1) begin
      @(negedge clk);
      exp_addr = (!cm && edges - 1 < n) ? edges - 1 : 0;
      if (rom_addr !== 11'(exp_addr)) addr_errs++;
      if (busy !== 1'b1) busy_errs++;
      if (plot) obs_q.push_back({x, y, color});
      if (done) begin
        done_at = edges;
        break;
      end
      if (edges > lim) break;
      if (disturb && edges == 100) begin
        start      = 1'b1;
        x_origin   = 8'($urandom);
        y_origin   = 7'($urandom);
        clear_mode = ~cm;
      end
      if (disturb && edges == 103) start = 1'b0;
      @(posedge clk);
      edges++;
    end
    check_eq({tag, ".done_edges"}, done_at, n + 3);
    check_eq({tag, ".rom_addr_errs"}, addr_errs, 0);
    check_eq({tag, ".busy_errs"}, busy_errs, 0);
    check_eq({tag, ".plot_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq($sformatf("%s.pix%0d", tag, i), obs_q[i], exp_q[i]);
      if (obs_q[i] !== exp_q[i]) break;
    end
    @(negedge clk);
    check_eq({tag, ".done_pulse_end"}, done, 1'b0);
    check_eq({tag, ".idle_after_done"}, busy, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int plots, done_errs, xo, yo;
    salt       = 3'd0;
    rst_n      = 1'b0;
    start      = 1'b1;
    clear_mode = 1'b0;
    x_origin   = 8'd0;
    y_origin   = 7'd30;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.x", x, 0);
    check_eq("rst.y", y, 0);
    check_eq("rst.color", color, 0);
    check_eq("rst.rom_addr", rom_addr, 0);
    check_eq("rst.plot", plot, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);

    // Start is already high, so the first edge after release launches the draw.
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    observe("spr0_30", 1'b0, 0, 30, 1'b0);
    check_eq("spr0_30.count", obs_q.size(), 1600);
    check_eq("spr0_30.first", obs_q[0], {8'd0, 7'd30, 3'd0});
    check_eq("spr0_30.last", obs_q[obs_q.size() - 1], {8'd39, 7'd69, 3'd7});

    launch(1'b0, 120, 30, 1'b0);
    observe("clip120_30", 1'b0, 120, 30, 1'b0);
    check_eq("clip120_30.count", obs_q.size(), 1600);
    launch(1'b0, 140, 100, 1'b0);
    observe("clip140_100", 1'b0, 140, 100, 1'b0);
    check_eq("clip140_100.count", obs_q.size(), 400);

    launch(1'b1, 77, 55, 1'b0);
    observe("clear", 1'b1, 77, 55, 1'b0);
    check_eq("clear.count", obs_q.size(), 19200);

    salt = 3'($urandom);
    launch(1'b0, 10, 20, 1'b0);
    observe("disturb", 1'b0, 10, 20, 1'b1);

    // Held start: one idle cycle after done, then the second draw begins.
    launch(1'b0, 50, 60, 1'b1);
    observe("held_a", 1'b0, 50, 60, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("held_b.busy_rise", busy, 1'b1);
    observe("held_b", 1'b0, 50, 60, 1'b0);

    for (int t = 0; t < 4; t++) begin
      salt = 3'($urandom);
      xo = $urandom_range(0, 255);
      yo = $urandom_range(0, 127);
      launch(1'b0, xo, yo, 1'b0);
      observe($sformatf("rand%0d", t), 1'b0, xo, yo, 1'b0);
    end

    // Abort mid-draw with reset.
    launch(1'b0, 5, 5, 1'b0);
    plots = 0;
    for (int c = 0; c < 2000 && plots < 500; c++) begin
      @(negedge clk);
      if (plot) plots++;
    end
    check_eq("abort.plots_seen", plots, 500);
    rst_n = 1'b0;
    #1;
    check_eq("abort.plot", plot, 1'b0);
    check_eq("abort.busy", busy, 1'b0);
    check_eq("abort.rom_addr", rom_addr, 0);
    check_eq("abort.x", x, 0);
    done_errs = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_errs++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) done_errs++;
    end
    check_eq("abort.no_done", done_errs, 0);
    salt = 3'($urandom);
    launch(1'b0, 100, 90, 1'b0);
    observe("after_abort", 1'b0, 100, 90, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
